// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - parametrised up/down counter with programmable bound, step, wrap/saturate mode and sticky flags
module up_down_counter_param #(
  parameter int WIDTH       = 8,
  parameter bit SAT_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             UPDN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic [WIDTH-1:0] LIMIT,
  input  logic [WIDTH-1:0] STEP,
  input  logic             MODE_WE,
  input  logic             MODE_SAT,
  input  logic             CLR_FLAGS,
  output logic [WIDTH-1:0] VALUE,
  output logic             TC,
  output logic             AT_MAX,
  output logic             AT_ZERO,
  output logic             OVF,
  output logic             UNF,
  output logic             SAT
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_value;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;
  logic             r_sat;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH:0]   w_v;
  logic [WIDTH:0]   w_lim;
  logic [WIDTH:0]   w_lim_p1;
  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_up_sum;
  logic [WIDTH:0]   w_up_wrap;
  logic [WIDTH:0]   w_down_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_tc;
  logic             w_set_ovf;
  logic             w_set_unf;

  assign w_step      = (STEP > LIMIT) ? LIMIT : STEP;
  assign w_load      = (LOAD_VALUE > LIMIT) ? LIMIT : LOAD_VALUE;
  // One extra bit keeps value+step and value+limit+1 from truncating.
  assign w_v         = {1'b0, r_value};
  assign w_lim       = {1'b0, LIMIT};
  assign w_s         = {1'b0, w_step};
  assign w_lim_p1    = w_lim + ONE;
  assign w_up_sum    = w_v + w_s;
  assign w_up_wrap   = w_up_sum - w_lim_p1;
  assign w_down_wrap = w_v + w_lim_p1 - w_s;

  always_comb begin
    w_next    = r_value;
    w_tc      = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (LOAD) begin
      w_next = w_load;
    end else if (ENABLE) begin
      if (w_v > w_lim) begin
        // Only reachable after LIMIT was lowered below the current count.
        w_next    = r_sat ? LIMIT : '0;
        w_tc      = 1'b1;
        w_set_ovf = UPDN;
        w_set_unf = ~UPDN;
      end else if (w_s != '0) begin
        if (UPDN) begin
          if (w_up_sum > w_lim) begin
            w_next    = r_sat ? LIMIT : w_up_wrap[WIDTH-1:0];
            w_tc      = 1'b1;
            w_set_ovf = 1'b1;
          end else begin
            w_next = w_up_sum[WIDTH-1:0];
          end
        end else begin
          if (w_v < w_s) begin
            w_next    = r_sat ? '0 : w_down_wrap[WIDTH-1:0];
            w_tc      = 1'b1;
            w_set_unf = 1'b1;
          end else begin
            w_next = r_value - w_step;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_value <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_sat   <= SAT_DEFAULT;
    end else begin
      r_value <= w_next;
      r_tc    <= w_tc;
      r_ovf   <= w_set_ovf | (r_ovf & ~CLR_FLAGS);
      r_unf   <= w_set_unf | (r_unf & ~CLR_FLAGS);
      if (MODE_WE) begin
        r_sat <= MODE_SAT;
      end
    end
  end

  assign VALUE   = r_value;
  assign TC      = r_tc;
  assign OVF     = r_ovf;
  assign UNF     = r_unf;
  assign SAT     = r_sat;
  assign AT_MAX  = (r_value == LIMIT);
  assign AT_ZERO = (r_value == '0);

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - directed and random checks of up_down_counter_param against an arithmetic model
module tb_up_down_counter_param;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         RST;
  logic         ENABLE;
  logic         UPDN;
  logic         LOAD;
  logic [W-1:0] LOAD_VALUE;
  logic [W-1:0] LIMIT;
  logic [W-1:0] STEP;
  logic         MODE_WE;
  logic         MODE_SAT;
  logic         CLR_FLAGS;
  logic [W-1:0] VALUE;
  logic         TC;
  logic         AT_MAX;
  logic         AT_ZERO;
  logic         OVF;
  logic         UNF;
  logic         SAT;

  int n_vec = 0;
  int n_err = 0;
  int m_v, m_tc, m_ovf, m_unf, m_sat;

  up_down_counter_param #(.WIDTH(W), .SAT_DEFAULT(1'b0)) dut (
    .clk(clk), .RST(RST), .ENABLE(ENABLE), .UPDN(UPDN), .LOAD(LOAD),
    .LOAD_VALUE(LOAD_VALUE), .LIMIT(LIMIT), .STEP(STEP), .MODE_WE(MODE_WE),
    .MODE_SAT(MODE_SAT), .CLR_FLAGS(CLR_FLAGS), .VALUE(VALUE), .TC(TC),
    .AT_MAX(AT_MAX), .AT_ZERO(AT_ZERO), .OVF(OVF), .UNF(UNF), .SAT(SAT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_sat = 0;
  endtask

  // Next state from the arithmetic rules: range is 0..L, wrap is modulo L+1.
  task automatic model_edge();
    int l, s, v, nv, tc, so, su;
    l = LIMIT; v = m_v; nv = v; tc = 0; so = 0; su = 0;
    s = (STEP < l) ? STEP : l;
    if (LOAD) begin
      nv = (LOAD_VALUE < l) ? LOAD_VALUE : l;
    end else if (ENABLE) begin
      if (v > l) begin
        nv = m_sat ? l : 0; tc = 1;
        if (UPDN) so = 1; else su = 1;
      end else if (s != 0) begin
        if (UPDN) begin
          if (v + s > l) begin nv = m_sat ? l : (v + s) % (l + 1); tc = 1; so = 1; end
          else nv = v + s;
        end else begin
          if (v < s) begin nv = m_sat ? 0 : (v - s + l + 1) % (l + 1); tc = 1; su = 1; end
          else nv = v - s;
        end
      end
    end
    if (CLR_FLAGS) begin m_ovf = 0; m_unf = 0; end
    if (so) m_ovf = 1;
    if (su) m_unf = 1;
    if (MODE_WE) m_sat = MODE_SAT;
    m_v = nv; m_tc = tc;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".value"}, VALUE, m_v);
    check({tag, ".tc"}, TC, m_tc);
    check({tag, ".ovf"}, OVF, m_ovf);
    check({tag, ".unf"}, UNF, m_unf);
    check({tag, ".sat"}, SAT, m_sat);
    check({tag, ".at_max"}, AT_MAX, (m_v == int'(LIMIT)));
    check({tag, ".at_zero"}, AT_ZERO, (m_v == 0));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    ENABLE = 0; LOAD = 0; MODE_WE = 0; CLR_FLAGS = 0;
  endtask

  task automatic do_load(input int val);
    idle(); LOAD = 1; LOAD_VALUE = W'(val); tick("load"); LOAD = 0;
  endtask

  task automatic set_mode(input logic sat);
    idle(); MODE_WE = 1; MODE_SAT = sat; tick("mode"); MODE_WE = 0;
  endtask

  initial begin
    RST = 1; idle(); UPDN = 1; LOAD_VALUE = '0; LIMIT = '0; STEP = '0; MODE_SAT = 0;
    model_reset();
    #12;
    compare_all("reset");
    RST = 0;

    // Wrap up through LIMIT=9.
    LIMIT = 9; STEP = 1; UPDN = 1; ENABLE = 1;
    for (int i = 0; i < 12; i++) tick("wrap_up");
    check("wrap_up.final", VALUE, 2);

    // Step wrap down: 1 + 10 - 3.
    STEP = 3; do_load(1);
    ENABLE = 1; UPDN = 0; tick("step_down");
    check("step_down.value", VALUE, 8);
    check("step_down.unf", UNF, 1);

    // Saturate clamps at both bounds.
    set_mode(1'b1);
    LIMIT = 200; do_load(199);
    STEP = 5; ENABLE = 1; UPDN = 1;
    for (int i = 0; i < 3; i++) tick("sat_up");
    check("sat_up.value", VALUE, 200);
    do_load(2);
    ENABLE = 1; UPDN = 0; tick("sat_down");
    check("sat_down.value", VALUE, 0);

    // Load beats enable and is clamped; oversized step is clamped to LIMIT.
    set_mode(1'b0);
    LIMIT = 100; LOAD = 1; LOAD_VALUE = 250; ENABLE = 1; UPDN = 1; tick("load_clamp");
    check("load_clamp.value", VALUE, 100);
    check("load_clamp.tc", TC, 0);
    LOAD = 0; STEP = 8'hFF; tick("step_clamp");
    check("step_clamp.value", VALUE, 99);

    // Limit lowered below the count.
    LIMIT = 200; do_load(50);
    LIMIT = 20; ENABLE = 1; UPDN = 1; tick("shrink_wrap");
    check("shrink_wrap.value", VALUE, 0);
    set_mode(1'b1);
    LIMIT = 200; do_load(50);
    LIMIT = 20; ENABLE = 1; UPDN = 0; tick("shrink_sat");
    check("shrink_sat.value", VALUE, 20);

    // Asynchronous reset between edges.
    LIMIT = 9; STEP = 1; UPDN = 1; ENABLE = 1; tick("pre_rst");
    #2 RST = 1;
    #1;
    model_reset();
    compare_all("async_rst");
    RST = 0;

    // Flag set wins over a simultaneous clear.
    do_load(9);
    ENABLE = 1; UPDN = 1; CLR_FLAGS = 1; tick("clr_vs_set");
    check("clr_vs_set.ovf", OVF, 1);
    idle(); CLR_FLAGS = 1; tick("clr_alone");
    check("clr_alone.ovf", OVF, 0);

    // Random traffic with occasional limit and mode changes.
    idle();
    for (int i = 0; i < 3000; i++) begin
      ENABLE    = ($urandom_range(0, 7) != 0);
      UPDN      = $urandom_range(0, 1);
      LOAD      = ($urandom_range(0, 15) == 0);
      LOAD_VALUE = W'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)
        LIMIT = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 12)) : W'($urandom_range(0, 255));
      STEP      = ($urandom_range(0, 3) != 0) ? W'($urandom_range(0, 4)) : W'($urandom_range(0, 255));
      MODE_WE   = ($urandom_range(0, 31) == 0);
      MODE_SAT  = $urandom_range(0, 1);
      CLR_FLAGS = ($urandom_range(0, 15) == 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
